// File: rtl/deserializer_if.sv
// Serial-in / parallel-out bus of the deserializer.
// The slave modport is the deserializer itself; the master modport is whatever
// drives the serial stream and consumes the rebuilt words.
interface deserializer_if #(
   parameter int DATA_W = 16,
   parameter int MOD_W  = $clog2(DATA_W)
);
   logic              ser_data_i;
   logic              ser_data_val_i;
   logic [DATA_W-1:0] deser_data_o;
   logic [MOD_W-1:0]  deser_data_mod_o;
   logic              deser_data_val_o;
   logic              err_o;
   logic              busy_o;

   modport slave (
      input  ser_data_i,
      input  ser_data_val_i,
      output deser_data_o,
      output deser_data_mod_o,
      output deser_data_val_o,
      output err_o,
      output busy_o
   );

   modport master (
      output ser_data_i,
      output ser_data_val_i,
      input  deser_data_o,
      input  deser_data_mod_o,
      input  deser_data_val_o,
      input  err_o,
      input  busy_o
   );
endinterface

// File: rtl/deserializer.sv
// deserializer: rebuilds parallel words from an MSB-first serial stream.
// A frame is a run of consecutive valid cycles; it closes after DATA_W bits or
// when ser_data_val_i drops. Frames shorter than MIN_LEN are dropped with err_o.
// Length code: bit count, with 0 meaning a full DATA_W-bit word.
// Optional feature macro DESER_RALIGN_EN: when defined, partial words are
// right-aligned (last bit at bit 0); otherwise they are left-aligned.
module deserializer #(
   parameter int DATA_W  = 16,
   parameter int MOD_W   = $clog2(DATA_W),
   parameter int MIN_LEN = 3
) (
   input  logic           clk_i,
   input  logic           arst_ni,
   deserializer_if.slave  bus
);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_RECV = 1'b1
   } state_t;

   localparam logic [MOD_W:0] LAST_CNT = (MOD_W+1)'(DATA_W - 1);
   localparam logic [MOD_W:0] MIN_CNT  = (MOD_W+1)'(MIN_LEN);
   localparam logic [MOD_W:0] FULL_CNT = (MOD_W+1)'(DATA_W);
   localparam logic [MOD_W:0] ONE_CNT  = {{MOD_W{1'b0}}, 1'b1};
   localparam logic [MOD_W:0] ZERO_CNT = {(MOD_W+1){1'b0}};

   state_t              state_q;
   logic [MOD_W:0]      cnt_q;
   // Only DATA_W-1 bits ever need storing: the last bit of a full word is
   // taken straight from the input on the completing edge.
   logic [DATA_W-2:0]   shift_q;
   logic [DATA_W-1:0]   data_q;
   logic [MOD_W-1:0]    mod_q;
   logic                val_q;
   logic                err_q;
   logic                busy_q;

   logic [DATA_W-1:0]   shift_d;
   logic [MOD_W:0]      cnt_d;
   logic [DATA_W-1:0]   word_d;

   // Next shift contents, incremented count and aligned partial word.
   always_comb begin
      shift_d = {shift_q, bus.ser_data_i};
      cnt_d   = cnt_q + ONE_CNT;
`ifdef DESER_RALIGN_EN
      // Received bits already sit at the bottom, high bits cleared at frame start.
      word_d  = {1'b0, shift_q};
`else
      // Move the cnt received bits up so the first one lands in the MSB.
      word_d  = {1'b0, shift_q} << (FULL_CNT - cnt_q);
`endif
   end

   // Receive FSM with registered word, length, pulse and busy outputs.
   always_ff @(posedge clk_i or negedge arst_ni) begin
      if (!arst_ni) begin
         state_q <= ST_IDLE;
         cnt_q   <= ZERO_CNT;
         shift_q <= {(DATA_W-1){1'b0}};
         data_q  <= {DATA_W{1'b0}};
         mod_q   <= {MOD_W{1'b0}};
         val_q   <= 1'b0;
         err_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         val_q <= 1'b0;
         err_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (bus.ser_data_val_i) begin
                  shift_q <= {{(DATA_W-2){1'b0}}, bus.ser_data_i};
                  cnt_q   <= ONE_CNT;
                  state_q <= ST_RECV;
                  busy_q  <= 1'b1;
               end else begin
                  cnt_q   <= ZERO_CNT;
                  busy_q  <= 1'b0;
               end
            end
            ST_RECV: begin
               if (bus.ser_data_val_i) begin
                  if (cnt_q == LAST_CNT) begin
                     // Last bit of a full word: emit now, free for a back-to-back frame.
                     data_q  <= shift_d;
                     mod_q   <= {MOD_W{1'b0}};
                     val_q   <= 1'b1;
                     cnt_q   <= ZERO_CNT;
                     state_q <= ST_IDLE;
                     busy_q  <= 1'b0;
                  end else begin
                     shift_q <= shift_d[DATA_W-2:0];
                     cnt_q   <= cnt_d;
                  end
               end else begin
                  // Frame closed early by the valid strobe dropping.
                  if (cnt_q >= MIN_CNT) begin
                     data_q <= word_d;
                     mod_q  <= cnt_q[MOD_W-1:0];
                     val_q  <= 1'b1;
                  end else begin
                     err_q  <= 1'b1;
                  end
                  cnt_q   <= ZERO_CNT;
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
               end
            end
            default: begin
               state_q <= ST_IDLE;
               cnt_q   <= ZERO_CNT;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.deser_data_o     = data_q;
   assign bus.deser_data_mod_o = mod_q;
   assign bus.deser_data_val_o = val_q;
   assign bus.err_o            = err_q;
   assign bus.busy_o           = busy_q;

endmodule

// File: tb/tb_deserializer.sv
// Directed self-checking bench for deserializer (DATA_W=16, MIN_LEN=3).
// Expected words follow DESER_RALIGN_EN when the macro is defined.
module tb_deserializer;

   logic clk;
   logic rst_n;
   int   total;
   int   bad;

   deserializer_if #(.DATA_W(16), .MOD_W(4)) bus ();

   deserializer #(.DATA_W(16), .MOD_W(4), .MIN_LEN(3)) dut (
      .clk_i   (clk),
      .arst_ni (rst_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Compare one observed value against its expectation.
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // One clock cycle with the given inputs; returns 1 time unit after the edge.
   task automatic drive(input logic v, input logic b);
      bus.ser_data_val_i = v;
      bus.ser_data_i     = b;
      @(posedge clk);
      #1;
   endtask

   // Send the top len bits of w, MSB first, on consecutive cycles.
   task automatic send_bits(input logic [15:0] w, input int len);
      for (int i = 0; i < len; i++) begin
         drive(1'b1, w[15-i]);
      end
   endtask

   // Expected word for a frame whose bits are the top len bits of w.
   function automatic logic [15:0] exp_word(input logic [15:0] w, input int len);
      logic [15:0] m;
      m = w & (16'hFFFF << (16 - len));
`ifdef DESER_RALIGN_EN
      return m >> (16 - len);
`else
      return m;
`endif
   endfunction

   task automatic chk_out(input string tag, input logic [15:0] d, input logic [3:0] m,
                          input logic v, input logic e);
      chk({tag, ".data"}, {16'h0000, bus.deser_data_o}, {16'h0000, d});
      chk({tag, ".mod"},  {28'h0, bus.deser_data_mod_o}, {28'h0, m});
      chk({tag, ".val"},  {31'h0, bus.deser_data_val_o}, {31'h0, v});
      chk({tag, ".err"},  {31'h0, bus.err_o}, {31'h0, e});
   endtask

   int          pulses;
   logic [15:0] rnd;
   logic [3:0]  mods [8];
   int          len;

   initial begin
      total = 0;
      bad   = 0;
      mods  = '{4'd0, 4'd3, 4'd7, 4'd15, 4'd4, 4'd12, 4'd5, 4'd9};
      rst_n = 1'b0;
      bus.ser_data_i     = 1'b0;
      bus.ser_data_val_i = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk_out("reset", 16'h0000, 4'd0, 1'b0, 1'b0);
      chk("reset.busy", {31'h0, bus.busy_o}, 32'h0);
      rst_n = 1'b1;
      drive(1'b0, 1'b1);
      chk("idle.busy", {31'h0, bus.busy_o}, 32'h0);

      // Full 16-bit word
      send_bits(16'hA5C3, 15);
      chk("full.busy", {31'h0, bus.busy_o}, 32'h1);
      chk("full.noval", {31'h0, bus.deser_data_val_o}, 32'h0);
      drive(1'b1, 1'b1);
      chk_out("full", 16'hA5C3, 4'd0, 1'b1, 1'b0);
      chk("full.busy_end", {31'h0, bus.busy_o}, 32'h0);
      drive(1'b0, 1'b0);
      chk("full.pulse1", {31'h0, bus.deser_data_val_o}, 32'h0);

      // 5-bit frame 1,0,1,1,0
      send_bits(16'hB000, 5);
      chk("p5.noval", {31'h0, bus.deser_data_val_o}, 32'h0);
      drive(1'b0, 1'b1);
      chk_out("p5", exp_word(16'hB000, 5), 4'd5, 1'b1, 1'b0);
      drive(1'b0, 1'b0);
      chk_out("p5.hold", exp_word(16'hB000, 5), 4'd5, 1'b0, 1'b0);

      // 2-bit frame: dropped with error, previous word kept
      send_bits(16'hC000, 2);
      drive(1'b0, 1'b0);
      chk_out("short2", exp_word(16'hB000, 5), 4'd5, 1'b0, 1'b1);
      drive(1'b0, 1'b0);
      chk("short2.err1", {31'h0, bus.err_o}, 32'h0);

      // 1-bit frame: error too
      send_bits(16'h8000, 1);
      drive(1'b0, 1'b0);
      chk_out("short1", exp_word(16'hB000, 5), 4'd5, 1'b0, 1'b1);
      drive(1'b0, 1'b0);

      // Exactly MIN_LEN bits
      send_bits(16'hA000, 3);
      drive(1'b0, 1'b0);
      chk_out("min3", exp_word(16'hA000, 3), 4'd3, 1'b1, 1'b0);
      drive(1'b0, 1'b0);

      // DATA_W-1 bits
      send_bits(16'hFFFF, 15);
      drive(1'b0, 1'b0);
      chk_out("len15", exp_word(16'hFFFF, 15), 4'd15, 1'b1, 1'b0);
      drive(1'b0, 1'b0);

      // Back-to-back full words 0x1234 then 0xFFFF
      send_bits(16'h1234, 16);
      chk_out("b2b.first", 16'h1234, 4'd0, 1'b1, 1'b0);
      pulses = 0;
      for (int i = 1; i < 16; i++) begin
         drive(1'b1, 1'b1);
         if (bus.deser_data_val_o) pulses++;
      end
      chk("b2b.gap_pulses", pulses, 0);
      drive(1'b1, 1'b1);
      chk_out("b2b.second", 16'hFFFF, 4'd0, 1'b1, 1'b0);
      drive(1'b0, 1'b0);
      chk_out("b2b.after", 16'hFFFF, 4'd0, 1'b0, 1'b0);

      // Reset after 8 bits of a frame
      send_bits(16'h5A00, 8);
      bus.ser_data_val_i = 1'b0;
      rst_n = 1'b0;
      #1;
      chk_out("midrst", 16'h0000, 4'd0, 1'b0, 1'b0);
      chk("midrst.busy", {31'h0, bus.busy_o}, 32'h0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      drive(1'b0, 1'b0);
      chk_out("midrst.quiet", 16'h0000, 4'd0, 1'b0, 1'b0);
      send_bits(16'hF000, 4);
      drive(1'b0, 1'b0);
      chk_out("after_rst4", exp_word(16'hF000, 4), 4'd4, 1'b1, 1'b0);
      drive(1'b0, 1'b0);

      // Loopback-style frames with random data and legal length codes
      for (int k = 0; k < 8; k++) begin
         rnd = 16'($urandom);
         len = (mods[k] == 4'd0) ? 16 : int'(mods[k]);
         send_bits(rnd, len);
         if (len != 16) drive(1'b0, 1'b0);
         chk_out($sformatf("loop%0d", k), exp_word(rnd, len), mods[k], 1'b1, 1'b0);
         drive(1'b0, 1'b0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
